// File: rtl/ex_mem_skid_reg.sv
// ============================================================================
// ex_mem_skid_reg
// ----------------------------------------------------------------------------
// EX->MEM pipeline register placed directly after the ALU. It captures the ALU
// result and zero flag, the store data, the destination register and the MEM/WB
// control bundle. These are passed to the MEM stage over a valid/ready
// handshake. A two-entry skid buffer (head + skid) lets ex_ready_o come straight
// from a flop while still sustaining one transfer per cycle. The head entry is
// also exported to the forwarding unit. A saturating counter records the cycles
// in which MEM applied back-pressure.
//
// Optional feature: define EXMEM_FLUSH_EN to add the flush_i port. When flush_i
// is high, all held entries are discarded and the incoming entry is dropped.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   ex_valid_i/ready_o  upstream handshake (ex_ready_o is registered)
//   ex_result_i, ex_zero_i, ex_wdata_i, ex_rd_addr_i, ex_ctrl_i
//                       incoming entry fields
//   mem_valid_o/ready_i downstream handshake
//   mem_result_o, mem_zero_o, mem_wdata_o, mem_rd_addr_o, mem_ctrl_o
//                       head entry fields
//   fwd_regwrite_o      head is valid and has RegWrite set
//   stall_cnt_o         saturating count of mem_valid_o & !mem_ready_i cycles
//   flush_i             (EXMEM_FLUSH_EN only) discard all entries
// ============================================================================
module ex_mem_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef EXMEM_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [DATA_W-1:0]     ex_result_i,
    input  logic                  ex_zero_i,
    input  logic [DATA_W-1:0]     ex_wdata_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic [CTRL_W-1:0]     ex_ctrl_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [DATA_W-1:0]     mem_result_o,
    output logic                  mem_zero_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [REG_ADDR_W-1:0] mem_rd_addr_o,
    output logic [CTRL_W-1:0]     mem_ctrl_o,
    output logic                  fwd_regwrite_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int ENT_W = DATA_W + 1 + DATA_W + REG_ADDR_W + CTRL_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic [ENT_W-1:0]   skid_q, skid_d;
    logic               ex_ready_q, ex_ready_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [ENT_W-1:0]   in_entry;
    logic               push, pop, flush;

`ifdef EXMEM_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign in_entry    = {ex_result_i, ex_zero_i, ex_wdata_i, ex_rd_addr_i, ex_ctrl_i};
    assign mem_valid_o = (state_q != S_EMPTY);
    assign push        = ex_valid_i & ex_ready_q;
    assign pop         = mem_valid_o & mem_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    // Head leaves and the new entry replaces it in place.
                    head_d = in_entry;
                end else if (push) begin
                    skid_d  = in_entry;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // ex_ready_o is low here, so only the skid-to-head move occurs.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush overrides any push. A same-cycle pop was still delivered.
        if (flush) begin
            state_d = S_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end

        // ex_ready_o is computed from the next state, so it leaves a flop.
        ex_ready_d = (state_d != S_FULL);

        stall_d = stall_q;
        if (mem_valid_o && !mem_ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            ex_ready_q <= ex_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_ready_o = ex_ready_q;
    assign {mem_result_o, mem_zero_o, mem_wdata_o, mem_rd_addr_o, mem_ctrl_o} = head_q;
    assign fwd_regwrite_o = mem_valid_o & mem_ctrl_o[CTRL_W-1];
    assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

    localparam int CNT_W   = 4;
    localparam int STALL_MAX = 15;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } entry_t;

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] d;
        logic        ev;
        logic        er;
        logic [31:0] eres;
        int          est;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
`ifdef EXMEM_FLUSH_EN
    logic        flush_i = 1'b0;
`endif
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] ex_result_i = '0;
    logic        ex_zero_i = 1'b0;
    logic [31:0] ex_wdata_i = '0;
    logic [4:0]  ex_rd_addr_i = '0;
    logic [4:0]  ex_ctrl_i = '0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_result_o;
    logic        mem_zero_o;
    logic [31:0] mem_wdata_o;
    logic [4:0]  mem_rd_addr_o;
    logic [4:0]  mem_ctrl_o;
    logic        fwd_regwrite_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an ordered list of held entries (max two) and a count.
    entry_t m_q[$];
    int     m_stall = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_skid_reg #(
        .DATA_W(32), .REG_ADDR_W(5), .CTRL_W(5), .CNT_W(CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
`ifdef EXMEM_FLUSH_EN
        .flush_i        (flush_i),
`endif
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_result_i    (ex_result_i),
        .ex_zero_i      (ex_zero_i),
        .ex_wdata_i     (ex_wdata_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_ctrl_i      (ex_ctrl_i),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_result_o   (mem_result_o),
        .mem_zero_o     (mem_zero_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_ctrl_o     (mem_ctrl_o),
        .fwd_regwrite_o (fwd_regwrite_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    function automatic entry_t mk(input logic [31:0] d);
        entry_t e;
        e.res   = d;
        e.zero  = (d == 32'd0);
        e.wdata = ~d;
        e.rd    = d[4:0];
        e.ctrl  = {1'b1, d[3:0]};
        return e;
    endfunction

    function automatic entry_t dut_head();
        return {mem_result_o, mem_zero_o, mem_wdata_o, mem_rd_addr_o, mem_ctrl_o};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic v, input logic r, input entry_t e, input logic fl);
        bit push, pop;
        ex_valid_i = v;
        mem_ready_i = r;
        {ex_result_i, ex_zero_i, ex_wdata_i, ex_rd_addr_i, ex_ctrl_i} = e;
`ifdef EXMEM_FLUSH_EN
        flush_i = fl;
`endif
        push = v && (m_q.size() < 2);
        pop  = (m_q.size() > 0) && r;
        if ((m_q.size() > 0) && !r && (m_stall < STALL_MAX)) m_stall++;
        if (pop) m_q.delete(0);
`ifdef EXMEM_FLUSH_EN
        if (fl) m_q.delete();
        else if (push) m_q.push_back(e);
`else
        if (push && !fl) m_q.push_back(e);
`endif
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ex_valid_i = 1'b0;
        mem_ready_i = 1'b0;
`ifdef EXMEM_FLUSH_EN
        flush_i = 1'b0;
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_q.delete();
        m_stall = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, mem_valid_o, 1'b0);
        chk({tag, "_ready"}, ex_ready_o, 1'b1);
        chk({tag, "_fwd"}, fwd_regwrite_o, 1'b0);
        chk({tag, "_stall"}, stall_cnt_o, '0);
        chk({tag, "_head"}, dut_head(), '0);
    endtask

    task automatic chk_model(input string tag);
        bit v;
        v = (m_q.size() > 0);
        chk({tag, "_valid"}, mem_valid_o, v);
        chk({tag, "_ready"}, ex_ready_o, m_q.size() < 2);
        chk({tag, "_stall"}, stall_cnt_o, m_stall);
        chk({tag, "_fwd"}, fwd_regwrite_o, v && m_q[0].ctrl[4]);
        if (v) chk({tag, "_head"}, dut_head(), m_q[0]);
    endtask

    initial begin
        vec_t   tbl[12];
        entry_t e;
        int     delivered;

        // Back-to-back stream, then A/B/C under back-pressure (C held), then
        // a simultaneous push/pop in ONE (record 10).
        tbl[0]  = '{1'b1, 1'b1, 32'd1,  1'b1, 1'b1, 32'd1,  0};
        tbl[1]  = '{1'b1, 1'b1, 32'd2,  1'b1, 1'b1, 32'd2,  0};
        tbl[2]  = '{1'b1, 1'b1, 32'd3,  1'b1, 1'b1, 32'd3,  0};
        tbl[3]  = '{1'b1, 1'b1, 32'd4,  1'b1, 1'b1, 32'd4,  0};
        tbl[4]  = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b1, 32'd0,  0};
        tbl[5]  = '{1'b1, 1'b0, 32'd10, 1'b1, 1'b1, 32'd10, 0};
        tbl[6]  = '{1'b1, 1'b0, 32'd11, 1'b1, 1'b0, 32'd10, 1};
        tbl[7]  = '{1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 32'd10, 2};
        tbl[8]  = '{1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 32'd10, 3};
        tbl[9]  = '{1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 32'd11, 3};
        tbl[10] = '{1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 32'd12, 3};
        tbl[11] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b1, 32'd0,  3};

        @(posedge clk_i);
        #1;
        do_reset();
        chk_reset_state("reset");
        $display("reset done");

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].r, mk(tbl[i].d), 1'b0);
            $display("vec %0d: valid=%0b ready=%0b result=%0d stall=%0d",
                     i, mem_valid_o, ex_ready_o, mem_result_o, stall_cnt_o);
            chk($sformatf("vec%0d_valid", i), mem_valid_o, tbl[i].ev);
            chk($sformatf("vec%0d_ready", i), ex_ready_o, tbl[i].er);
            chk($sformatf("vec%0d_stall", i), stall_cnt_o, tbl[i].est);
            chk($sformatf("vec%0d_fwd", i), fwd_regwrite_o, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("vec%0d_head", i), dut_head(), mk(tbl[i].eres));
        end

        // Stall counter saturation at 2^CNT_W-1.
        step(1'b1, 1'b0, mk(32'd5), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, mk(32'd0), 1'b0);
        $display("saturation: stall=%0d", stall_cnt_o);
        chk("sat_stall", stall_cnt_o, 4'd15);
        chk("sat_head", mem_result_o, 32'd5);
        step(1'b0, 1'b0, mk(32'd0), 1'b0);
        chk("sat_hold", stall_cnt_o, 4'd15);

        // Reset while FULL.
        do_reset();
        step(1'b1, 1'b0, mk(32'hAA), 1'b0);
        step(1'b1, 1'b0, mk(32'hBB), 1'b0);
        chk("full_ready", ex_ready_o, 1'b0);
        do_reset();
        $display("reset while full: valid=%0b ready=%0b", mem_valid_o, ex_ready_o);
        chk_reset_state("rst_full");

`ifdef EXMEM_FLUSH_EN
        // Flush while FULL with an offered entry, and flush beating a push in ONE.
        step(1'b1, 1'b0, mk(32'h21), 1'b0);
        step(1'b1, 1'b0, mk(32'h22), 1'b0);
        step(1'b1, 1'b0, mk(32'h23), 1'b1);
        chk("flush_full_valid", mem_valid_o, 1'b0);
        chk("flush_full_ready", ex_ready_o, 1'b1);
        step(1'b1, 1'b1, mk(32'h31), 1'b0);
        step(1'b1, 1'b0, mk(32'h32), 1'b1);
        chk("flush_one_valid", mem_valid_o, 1'b0);
        step(1'b1, 1'b0, mk(32'h33), 1'b0);
        chk("flush_next_head", mem_result_o, 32'h33);
        chk("flush_stall", stall_cnt_o, m_stall);
        $display("flush sequence done");
        do_reset();
`endif

        // Randomized traffic against the queue model.
        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            logic v, r, fl;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 9) < 6);
            fl = 1'b0;
`ifdef EXMEM_FLUSH_EN
            fl = ($urandom_range(0, 19) == 0);
`endif
            e = {$urandom(), 1'b0, $urandom(), 5'($urandom()), 5'($urandom())};
            e.zero = (e.res == 32'd0);
            if (mem_valid_o && r) begin
                delivered++;
                $display("pop %0d: result=%h rd=%0d", delivered, mem_result_o, mem_rd_addr_o);
            end
            step(v, r, e, fl);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
